mem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single-port data memory between the cpu and a second master (loader / debug / DMA port).
- Sits between the requesters and the memory module and drives mem_we/mem_addr/mem_data.
- Uses round-robin arbitration with a per-master req/gnt handshake.
- Read data is returned with a per-master rvalid tag aligned to the memory's synchronous read latency.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/rr_arbiter_2.sv | 34 +++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM states, master indices
// and the read-tag type carried down the read-latency pipeline.
package mem_arbiter_pkg;

  localparam int NUM_MASTERS = 2;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  function automatic logic [NUM_MASTERS-1:0] id_to_onehot(input logic id);
    return (id == M_AUX) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin winner pick; the master that did not win last time wins a tie.
// With MEM_ARB_LOCK_EN defined, a requesting last winner holding its lock keeps the bus.
module rr_arbiter_2
  import mem_arbiter_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   last,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0] lock,
`endif
  output logic                   any_req,
  output logic                   winner
);

  always_comb begin
    any_req = |req;
    winner  = M_CPU;
`ifdef MEM_ARB_LOCK_EN
    if (lock[last] && req[last]) begin
      winner = last;
    end else begin
`else
    begin
`endif
      case (req)
        2'b01:   winner = M_CPU;
        2'b10:   winner = M_AUX;
        2'b11:   winner = ~last;
        default: winner = M_CPU;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous memory, with per-master
// read-valid tags aligned to READ_LAT (1..3). Optional bus lock via MEM_ARB_LOCK_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int READ_LAT   = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            req,
  input  logic [NUM_MASTERS-1:0]            we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]            lock,
`endif
  output logic [NUM_MASTERS-1:0]            gnt,
  output logic [NUM_MASTERS-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]             rdata,
  input  logic [DATA_WIDTH-1:0]             mem_in,
  output logic                              mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_data
);

  arb_state_e             state, state_next;
  logic                   last, last_next;
  logic [NUM_MASTERS-1:0] gnt_next;
  logic                   mem_we_next;
  logic [ADDR_WIDTH-1:0]  mem_addr_next;
  logic [DATA_WIDTH-1:0]  mem_data_next;
  logic                   any_req;
  logic                   winner;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  rd_tag_t                tag_in;
  rd_tag_t                tag_pipe [READ_LAT];

  rr_arbiter_2 u_rr (
    .req     (req),
    .last    (last),
`ifdef MEM_ARB_LOCK_EN
    .lock    (lock),
`endif
    .any_req (any_req),
    .winner  (winner)
  );

  assign sel_addr  = winner ? addr[ADDR_WIDTH +: ADDR_WIDTH]  : addr[0 +: ADDR_WIDTH];
  assign sel_wdata = winner ? wdata[DATA_WIDTH +: DATA_WIDTH] : wdata[0 +: DATA_WIDTH];

  // mem_addr is left holding after an access; everything else returns to zero.
  always_comb begin
    state_next    = state;
    last_next     = last;
    gnt_next      = '0;
    mem_we_next   = 1'b0;
    mem_addr_next = mem_addr;
    mem_data_next = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_next      = id_to_onehot(winner);
          mem_we_next   = we[winner];
          mem_addr_next = sel_addr;
          mem_data_next = sel_wdata;
          last_next     = winner;
          state_next    = ISSUE;
        end
      end
      ISSUE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= M_AUX;
      gnt      <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      state    <= state_next;
      last     <= last_next;
      gnt      <= gnt_next;
      mem_we   <= mem_we_next;
      mem_addr <= mem_addr_next;
      mem_data <= mem_data_next;
    end
  end

  // A read tag is captured as the ISSUE cycle closes, matching the memory's first read stage.
  assign tag_in = {(state == ISSUE) && !mem_we, gnt[M_AUX]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign rvalid = tag_pipe[READ_LAT-1].valid ? id_to_onehot(tag_pipe[READ_LAT-1].id) : '0;
  assign rdata  = mem_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (READ_LAT 1 and 3) share stimulus and are compared
// every cycle against a transaction-level model; define MEM_ARB_LOCK_EN to cover the bus lock.
module tb_mem_arbiter;

  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int HIST  = 1024;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req, we;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
`ifdef MEM_ARB_LOCK_EN
  logic [1:0]      lock;
`endif

  logic [1:0]    gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b, mem_in_a, mem_in_b, mem_data_a, mem_data_b;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic          mem_we_a, mem_we_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef MEM_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a), .mem_in(mem_in_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(LAT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef MEM_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b), .mem_in(mem_in_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b)
  );

  // Unwritten locations read back a fixed pattern; address 5 holds BEEF.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return (a == 6'd5) ? 16'hBEEF : (16'hA000 | {10'd0, a});
  endfunction

  // Bench memories clear their write history on reset so they stay in step with the model.
  logic          wr_a [64];
  logic [DW-1:0] wv_a [64];
  logic          wr_b [64];
  logic [DW-1:0] wv_b [64];
  logic [DW-1:0] rd_b [LAT_B];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) wr_a[i] <= 1'b0;
    end else begin
      if (mem_we_a) begin
        wr_a[mem_addr_a] <= 1'b1;
        wv_a[mem_addr_a] <= mem_data_a;
      end
      mem_in_a <= wr_a[mem_addr_a] ? wv_a[mem_addr_a] : pat(mem_addr_a);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) wr_b[i] <= 1'b0;
    end else begin
      if (mem_we_b) begin
        wr_b[mem_addr_b] <= 1'b1;
        wv_b[mem_addr_b] <= mem_data_b;
      end
      rd_b[0] <= wr_b[mem_addr_b] ? wv_b[mem_addr_b] : pat(mem_addr_b);
      rd_b[1] <= rd_b[0];
      rd_b[2] <= rd_b[1];
    end
  end
  assign mem_in_b = rd_b[LAT_B-1];

  // Transaction model: a grant lasts one cycle, then the access completes; completed reads
  // are logged by edge number so each latency variant can look up what it owes.
  logic [1:0]    m_gnt;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_wr [64];
  logic [DW-1:0] m_wv [64];
  bit            rd_valid [HIST];
  bit            rd_id    [HIST];
  logic [DW-1:0] rd_data  [HIST];
  int            cyc = 16;
  logic [1:0]    lk_now;

`ifdef MEM_ARB_LOCK_EN
  assign lk_now = lock;
`else
  assign lk_now = 2'b00;
`endif

  function automatic logic pick(input logic [1:0] r, input logic lst, input logic [1:0] lk);
    if (lk[lst] && r[lst]) return lst;
    if (r == 2'b11) return ~lst;
    return r[1];
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return m_wr[a] ? m_wv[a] : pat(a);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_gnt  <= 2'b00;
      m_we   <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      m_last <= 1'b1;
      for (int i = 0; i < HIST; i++) rd_valid[i] <= 1'b0;
      for (int i = 0; i < 64; i++) m_wr[i] <= 1'b0;
    end else begin
      cyc                <= cyc + 1;
      rd_valid[cyc + 1]  <= (m_gnt != 2'b00) && !m_we;
      rd_id[cyc + 1]     <= m_gnt[1];
      rd_data[cyc + 1]   <= model_read(m_addr);
      if (m_gnt != 2'b00) begin
        if (m_we) begin
          m_wr[m_addr] <= 1'b1;
          m_wv[m_addr] <= m_data;
        end
        m_gnt  <= 2'b00;
        m_we   <= 1'b0;
        m_data <= '0;
      end else if (req != 2'b00) begin
        m_gnt  <= pick(req, m_last, lk_now) ? 2'b10 : 2'b01;
        m_we   <= we[pick(req, m_last, lk_now)];
        m_addr <= addr[(pick(req, m_last, lk_now) ? AW : 0) +: AW];
        m_data <= wdata[(pick(req, m_last, lk_now) ? DW : 0) +: DW];
        m_last <= pick(req, m_last, lk_now);
      end
    end
  end

  function automatic logic [1:0] exp_rv(input int idx);
    if (idx < 0 || idx >= HIST) return 2'b00;
    if (!rd_valid[idx]) return 2'b00;
    return rd_id[idx] ? 2'b10 : 2'b01;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("gnt_a",      32'(gnt_a),      32'(m_gnt));
    checkOutput("mem_we_a",   32'(mem_we_a),   32'(m_we));
    checkOutput("mem_addr_a", 32'(mem_addr_a), 32'(m_addr));
    checkOutput("mem_data_a", 32'(mem_data_a), 32'(m_data));
    checkOutput("rvalid_a",   32'(rvalid_a),   32'(exp_rv(cyc - LAT_A + 1)));
    if (exp_rv(cyc - LAT_A + 1) != 2'b00)
      checkOutput("rdata_a", 32'(rdata_a), 32'(rd_data[cyc - LAT_A + 1]));
    checkOutput("gnt_b",      32'(gnt_b),      32'(m_gnt));
    checkOutput("mem_we_b",   32'(mem_we_b),   32'(m_we));
    checkOutput("mem_addr_b", 32'(mem_addr_b), 32'(m_addr));
    checkOutput("mem_data_b", 32'(mem_data_b), 32'(m_data));
    checkOutput("rvalid_b",   32'(rvalid_b),   32'(exp_rv(cyc - LAT_B + 1)));
    if (exp_rv(cyc - LAT_B + 1) != 2'b00)
      checkOutput("rdata_b", 32'(rdata_b), 32'(rd_data[cyc - LAT_B + 1]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req   = r;
    we    = w;
    addr  = {a1, a0};
    wdata = {d1, d0};
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic setLock(input logic [1:0] lk);
    lock = lk;
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
`ifdef MEM_ARB_LOCK_EN
    setLock(2'b00);
`endif
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_gnt",      32'(gnt_a),      32'h0);
    checkOutput("rst_mem_we",   32'(mem_we_a),   32'h0);
    checkOutput("rst_mem_addr", 32'(mem_addr_a), 32'h0);
    checkOutput("rst_mem_data", 32'(mem_data_a), 32'h0);
    checkOutput("rst_rvalid",   32'(rvalid_b),   32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // single read of address 5 by master 0
    applyStimulus(2'b01, 2'b00, 6'd5, 6'd0, 16'h0, 16'h0);
    tick();
    @(negedge clk);
    checkOutput("rd_gnt",  32'(gnt_a),      32'h1);
    checkOutput("rd_addr", 32'(mem_addr_a), 32'd5);
    tick();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("rd_rvalid_l1", 32'(rvalid_a), 32'h1);
    checkOutput("rd_rdata_l1",  32'(rdata_a),  32'hBEEF);
    tick();
    tick();
    @(negedge clk);
    checkOutput("rd_rvalid_l3", 32'(rvalid_b), 32'h1);
    checkOutput("rd_rdata_l3",  32'(rdata_b),  32'hBEEF);
    tick();

    // master 1 writes 1234 to address 63, then master 0 reads it back
    applyStimulus(2'b10, 2'b10, 6'd0, 6'd63, 16'h0, 16'h1234);
    tick();
    @(negedge clk);
    checkOutput("wr_gnt",  32'(gnt_a),      32'h2);
    checkOutput("wr_we",   32'(mem_we_a),   32'h1);
    checkOutput("wr_addr", 32'(mem_addr_a), 32'd63);
    checkOutput("wr_data", 32'(mem_data_a), 32'h1234);
    tick();
    applyStimulus(2'b01, 2'b00, 6'd63, 6'd0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("wr_no_rvalid", 32'(rvalid_a), 32'h0);
    tick();
    @(negedge clk);
    checkOutput("raw_gnt", 32'(gnt_a), 32'h1);
    tick();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("raw_rvalid", 32'(rvalid_a), 32'h1);
    checkOutput("raw_rdata",  32'(rdata_a),  32'h1234);
    repeat (4) tick();

    // pipelined reads 0:1, 1:2, 0:3 returning in order on the latency-3 instance
    applyStimulus(2'b01, 2'b00, 6'd1, 6'd0, 16'h0, 16'h0);
    tick();
    tick();
    applyStimulus(2'b10, 2'b00, 6'd0, 6'd2, 16'h0, 16'h0);
    tick();
    tick();
    applyStimulus(2'b01, 2'b00, 6'd3, 6'd0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("pipe_rv0", 32'(rvalid_b), 32'h1);
    checkOutput("pipe_rd0", 32'(rdata_b),  32'hA001);
    tick();
    tick();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("pipe_rv1", 32'(rvalid_b), 32'h2);
    checkOutput("pipe_rd1", 32'(rdata_b),  32'hA002);
    tick();
    tick();
    @(negedge clk);
    checkOutput("pipe_rv2", 32'(rvalid_b), 32'h1);
    checkOutput("pipe_rd2", 32'(rdata_b),  32'hA003);
    repeat (3) tick();

    // reset the cycle after a read issue, then contend from a fresh reset
    applyStimulus(2'b01, 2'b00, 6'd7, 6'd0, 16'h0, 16'h0);
    tick();
    tick();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_gnt",    32'(gnt_a),      32'h0);
    checkOutput("mid_rst_rvalid", 32'(rvalid_a),   32'h0);
    checkOutput("mid_rst_addr",   32'(mem_addr_a), 32'h0);
    tick();
    rst_n = 1'b1;
    applyStimulus(2'b11, 2'b00, 6'd10, 6'd20, 16'h1111, 16'h2222);
    tick();
    @(negedge clk);
    checkOutput("cont_gnt0",      32'(gnt_a),    32'h1);
    checkOutput("stale_rvalid_b", 32'(rvalid_b), 32'h0);
    tick();
    tick();
    @(negedge clk);
    checkOutput("cont_gnt1", 32'(gnt_a), 32'h2);
    tick();
    tick();
    @(negedge clk);
    checkOutput("cont_gnt2", 32'(gnt_a), 32'h1);
    tick();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
    repeat (4) tick();

`ifdef MEM_ARB_LOCK_EN
    // master 0 (last winner) holds lock while both request
    setLock(2'b01);
    applyStimulus(2'b11, 2'b00, 6'd8, 6'd9, 16'h0, 16'h0);
    tick();
    @(negedge clk);
    checkOutput("lock_gnt0", 32'(gnt_a), 32'h1);
    tick();
    tick();
    @(negedge clk);
    checkOutput("lock_gnt1", 32'(gnt_a), 32'h1);
    tick();
    tick();
    @(negedge clk);
    checkOutput("lock_gnt2", 32'(gnt_a), 32'h1);
    tick();
    setLock(2'b00);
    tick();
    @(negedge clk);
    checkOutput("unlock_gnt", 32'(gnt_a), 32'h2);
    tick();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
`endif

    repeat (6) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
